// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: sequencer/arbiter for one single-port branch-predictor
// counter SRAM.
//
// After reset or flush it runs an init sweep that writes InitValue to every
// entry. After the sweep it shares the single SRAM port between frontend
// lookups (reads) and buffered commit-side saturating-counter updates (writes).
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   flush_i                    restart the sweep and drop queued updates
//   busy_o                     sweep in progress
//   lookup_valid_i/idx_i       read request
//   lookup_ready_o             read granted this cycle
//   lookup_rvalid_o/rdata_o    read response, one cycle after the grant
//   upd_valid_i/idx_i/taken_i/ctr_i, upd_ready_o   update request
//   mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i     SRAM port
module bp_table_ctrl #(
  parameter int IndexBits = 8,
  parameter int CtrBits   = 2,
  parameter int UpdQDepth = 2,
  parameter int InitValue = 2**(CtrBits-1)-1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 busy_o,
  input  logic                 lookup_valid_i,
  input  logic [IndexBits-1:0] lookup_idx_i,
  output logic                 lookup_ready_o,
  output logic                 lookup_rvalid_o,
  output logic [CtrBits-1:0]   lookup_rdata_o,
  input  logic                 upd_valid_i,
  input  logic [IndexBits-1:0] upd_idx_i,
  input  logic                 upd_taken_i,
  input  logic [CtrBits-1:0]   upd_ctr_i,
  output logic                 upd_ready_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [IndexBits-1:0] mem_addr_o,
  output logic [CtrBits-1:0]   mem_wdata_o,
  input  logic [CtrBits-1:0]   mem_rdata_i
);

  localparam int PtrW = (UpdQDepth > 1) ? $clog2(UpdQDepth) : 1;
  localparam int CntW = $clog2(UpdQDepth + 1);
  localparam logic [CtrBits-1:0] InitVal = CtrBits'(InitValue);
  localparam logic [CtrBits:0]   MaxCtr  = {1'b0, {CtrBits{1'b1}}};

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [IndexBits-1:0] idx;
    logic [CtrBits-1:0]   ctr;
  } upd_t;

  state_e               state_q;
  logic [IndexBits-1:0] sweep_q;
  logic                 rvalid_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      cnt_q;
  upd_t                 q_mem [UpdQDepth];

  logic run, full, empty, enq, deq, rd_grant;
  logic [CtrBits:0]   ctr_ext, ctr_inc, ctr_dec;
  logic [CtrBits-1:0] new_ctr;
  upd_t               head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(UpdQDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run   = (state_q == RUN);
  assign full  = (cnt_q == CntW'(UpdQDepth));
  assign empty = (cnt_q == '0);
  assign head  = q_mem[rd_ptr_q];

  // A full queue wins over lookups so that updates can never starve.
  assign deq      = run && !empty && (full || !lookup_valid_i);
  assign rd_grant = run && !full && lookup_valid_i;
  // Updates seen during the sweep are acked but dropped: the sweep rewrites
  // the whole table anyway, and the queue is empty then, so !full holds.
  assign enq      = run && upd_valid_i && !full;

  assign busy_o         = !run;
  assign lookup_ready_o = rd_grant;
  assign upd_ready_o    = !full;

  // Saturating step computed one bit wider so neither end wraps.
  assign ctr_ext = {1'b0, upd_ctr_i};
  assign ctr_inc = ctr_ext + 1'b1;
  assign ctr_dec = ctr_ext - 1'b1;
  always_comb begin
    new_ctr = '0;
    if (upd_taken_i) new_ctr = (ctr_inc > MaxCtr) ? MaxCtr[CtrBits-1:0] : ctr_inc[CtrBits-1:0];
    else             new_ctr = ctr_dec[CtrBits] ? '0 : ctr_dec[CtrBits-1:0];
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!run) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = sweep_q;
      mem_wdata_o = InitVal;
    end else if (deq) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = head.idx;
      mem_wdata_o = head.ctr;
    end else if (rd_grant) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = lookup_idx_i;
    end
  end

  // The SRAM drives read data in the cycle after the request, which is the
  // cycle rvalid_q is high; the data is gated so the port idles at zero.
  assign lookup_rvalid_o = rvalid_q;
  assign lookup_rdata_o  = rvalid_q ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= INIT;
      sweep_q  <= '0;
      rvalid_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // A read granted in the flush cycle still gets its response.
      rvalid_q <= rd_grant;
      if (flush_i) begin
        state_q  <= INIT;
        sweep_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          INIT: begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == {IndexBits{1'b1}}) state_q <= RUN;
          end
          default: begin
            if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (enq && !deq)      cnt_q <= cnt_q + 1'b1;
            else if (deq && !enq) cnt_q <= cnt_q - 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) q_mem[wr_ptr_q] <= '{idx: upd_idx_i, ctr: new_ctr};
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
module tb_bp_table_ctrl;
  localparam int IB = 4;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          busy, lk_valid, lk_ready, lk_rvalid;
  logic [IB-1:0] lk_idx;
  logic [CB-1:0] lk_rdata;
  logic          up_valid, up_taken, up_ready;
  logic [IB-1:0] up_idx;
  logic [CB-1:0] up_ctr;
  logic          m_req, m_we;
  logic [IB-1:0] m_addr;
  logic [CB-1:0] m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [IB+CB-1:0] exp_wr [$];   // {addr, data}
  logic [CB-1:0]    exp_rd [$];
  logic [CB-1:0]    smem [16];

  always #5 clk = ~clk;

  bp_table_ctrl #(.IndexBits(IB), .CtrBits(CB), .UpdQDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
    .lookup_valid_i(lk_valid), .lookup_idx_i(lk_idx), .lookup_ready_o(lk_ready),
    .lookup_rvalid_o(lk_rvalid), .lookup_rdata_o(lk_rdata),
    .upd_valid_i(up_valid), .upd_idx_i(up_idx), .upd_taken_i(up_taken),
    .upd_ctr_i(up_ctr), .upd_ready_o(up_ready),
    .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_o(m_addr),
    .mem_wdata_o(m_wdata), .mem_rdata_i(m_rdata)
  );

  // Single-port SRAM model: read data valid in the cycle after the request.
  always @(posedge clk) begin
    if (m_req) begin
      if (m_we) smem[m_addr] <= m_wdata;
      else      m_rdata <= smem[m_addr];
    end
  end

  // Scoreboard: every SRAM write and every read response is matched in order.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_req && m_we) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", m_addr, m_wdata);
        end else begin
          logic [IB+CB-1:0] e;
          e = exp_wr.pop_front();
          if ({m_addr, m_wdata} !== e) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     m_addr, m_wdata, e[IB+CB-1:CB], e[CB-1:0]);
          end
        end
      end
      if (lk_rvalid) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got rdata=%0d, required no response", lk_rdata);
        end else begin
          logic [CB-1:0] r;
          r = exp_rd.pop_front();
          if (lk_rdata !== r) begin
            bad++;
            $display("FAIL rdata: got %0d, required %0d", lk_rdata, r);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_sweep();
    for (int a = 0; a < 16; a++) exp_wr.push_back({4'(a), 2'b01});
  endtask

  function automatic logic [CB-1:0] model_ctr(input logic t, input logic [CB-1:0] c);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; lk_valid = 1'b0; lk_idx = '0;
    up_valid = 1'b0; up_idx = '0; up_taken = 1'b0; up_ctr = '0;
    repeat (3) cyc();
    @(negedge clk);
    total++;
    if ({busy, lk_ready, up_ready, lk_rvalid, lk_rdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL reset: got busy=%b lready=%b uready=%b rvalid=%b rdata=%0d, required 1 0 1 0 0",
               busy, lk_ready, up_ready, lk_rvalid, lk_rdata);
    end
  endtask

  task automatic test_sweep();
    @(posedge clk); #1;
    push_sweep();
    rst_n = 1'b1; chk_en = 1'b1; lk_valid = 1'b1; lk_idx = 4'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || lk_ready !== 1'b0) begin
        bad++;
        $display("FAIL sweep_busy[%0d]: got busy=%b lready=%b, required 1 0", i, busy, lk_ready);
      end
      cyc();
    end
    lk_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL sweep_end: got busy=%b pending=%0d, required 0 0", busy, exp_wr.size());
    end
    cyc();
  endtask

  task automatic test_update_idle();
    logic [IB-1:0] ix [4] = '{4'd3, 4'd5, 4'd9, 4'd12};
    logic          tk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [CB-1:0] ct [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [CB-1:0] ex [4] = '{2'd3, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_idx = ix[i]; up_taken = tk[i]; up_ctr = ct[i];
      @(negedge clk);
      total++;
      if (up_ready !== 1'b1 || m_req !== 1'b0) begin
        bad++;
        $display("FAIL upd_accept[%0d]: got uready=%b req=%b, required 1 0", i, up_ready, m_req);
      end
      exp_wr.push_back({ix[i], ex[i]});
      cyc();
      up_valid = 1'b0;
      @(negedge clk);
      total++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== ix[i]) begin
        bad++;
        $display("FAIL upd_write[%0d]: got req=%b we=%b addr=%0d, required 1 1 %0d",
                 i, m_req, m_we, m_addr, ix[i]);
      end
      cyc();
    end
  endtask

  task automatic test_lookup();
    lk_valid = 1'b1; lk_idx = 4'd5;
    @(negedge clk);
    total++;
    if (lk_ready !== 1'b1 || m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 4'd5) begin
      bad++;
      $display("FAIL lookup_grant: got ready=%b req=%b we=%b addr=%0d, required 1 1 0 5",
               lk_ready, m_req, m_we, m_addr);
    end
    exp_rd.push_back(2'b10);   // written by the (taken, ctr=1) update at idx 5
    cyc();
    lk_valid = 1'b0;
    @(negedge clk);
    total++;
    if (lk_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL lookup_rvalid: got %b, required 1", lk_rvalid);
    end
    cyc();
    @(negedge clk);
    total++;
    if (lk_rvalid !== 1'b0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL lookup_idle: got rvalid=%b pending=%0d, required 0 0", lk_rvalid, exp_rd.size());
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int c = 0;
    while (sent < 6 && c < 40) begin
      lk_valid = 1'b1; lk_idx = 4'($urandom_range(0, 15));
      up_valid = 1'b1; up_idx = 4'(sent + 1); up_taken = sent[0]; up_ctr = 2'(sent);
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (up_ready !== 1'b0 || lk_ready !== 1'b0 || m_we !== 1'b1) begin
          bad++;
          $display("FAIL queue_full: got uready=%b lready=%b we=%b, required 0 0 1", up_ready, lk_ready, m_we);
        end
      end
      if (lk_ready) exp_rd.push_back(smem[lk_idx]);
      if (up_ready) begin
        exp_wr.push_back({up_idx, model_ctr(up_taken, up_ctr)});
        sent++;
      end
      cyc();
      c++;
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    c = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && c < 20) begin cyc(); c++; end
    total++;
    if (sent != 6 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got sent=%0d pend_wr=%0d pend_rd=%0d, required 6 0 0",
               sent, exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_flush_sweep();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int a = 0; a < 8; a++) exp_wr.push_back({4'(a), 2'b01});
    for (int i = 0; i < 8; i++) begin
      if (i == 7) flush = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL flush_busy[%0d]: got %b, required 1", i, busy);
      end
      cyc();
      flush = 1'b0;
    end
    push_sweep();
    for (int i = 0; i < 16; i++) cyc();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL flush_restart: got busy=%b pending=%0d, required 0 0", busy, exp_wr.size());
    end
    cyc();
  endtask

  // Two queued updates, then flush: only the head write that the full queue
  // issues in the flush cycle itself happens; the second update is lost and
  // updates offered during the sweep are acked but never written.
  task automatic test_flush_queue();
    for (int i = 0; i < 2; i++) begin
      lk_valid = 1'b1; lk_idx = 4'(i);
      up_valid = 1'b1; up_idx = 4'(10 + i); up_taken = 1'b1; up_ctr = 2'd0;
      @(negedge clk);
      if (lk_ready) exp_rd.push_back(smem[lk_idx]);
      if (i == 0) exp_wr.push_back({4'd10, 2'd1});
      cyc();
    end
    lk_valid = 1'b0; up_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    total++;
    if (up_ready !== 1'b0) begin
      bad++;
      $display("FAIL flushq_full: got uready=%b, required 0", up_ready);
    end
    cyc();
    flush = 1'b0;
    push_sweep();
    for (int i = 0; i < 16; i++) begin
      up_valid = 1'b1; up_idx = 4'($urandom_range(0, 15)); up_taken = 1'($urandom_range(0, 1));
      up_ctr = 2'($urandom_range(0, 3));
      @(negedge clk);
      total++;
      if (up_ready !== 1'b1) begin
        bad++;
        $display("FAIL init_upd_ready[%0d]: got %b, required 1", i, up_ready);
      end
      cyc();
    end
    up_valid = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_req !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL flushq_end: got busy=%b req=%b pend_wr=%0d pend_rd=%0d, required 0 0 0 0",
               busy, m_req, exp_wr.size(), exp_rd.size());
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_update_idle();
    test_lookup();
    test_back_to_back();
    test_flush_sweep();
    test_flush_queue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
